spi_master: RTL and testbench

// - SPI initiator for the AES SPI slave; one clock domain.
// - One frame, CS held low throughout:
//   - sends 128 data bits, then 256 key bits;
//   - waits a turnaround gap while the slave computes;
//   - reads back the 128-bit encrypted/decrypted result.
// - Sits between the host/bench logic and the slave's SDI/SDO/CS pins; SCK is derived from clk.

---
 rtl/spi_master_if.sv | 22 ++
 rtl/spi_master.sv | 158 +++++++++++++++
 tb/tb_spi_master.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Host-side request/response bundle of the SPI initiator for the AES slave.
// The master modport is the host, the slave modport is the spi_master block.
interface spi_master_if;
   logic         start;
   logic [1:0]   nk_sel;
   logic [127:0] data_in;
   logic [255:0] key_in;
   logic [1:0]   nk_val;
   logic         busy;
   logic         done;
   logic [127:0] data_out;

   modport master (
      output start, nk_sel, data_in, key_in,
      input  nk_val, busy, done, data_out
   );

   modport slave (
      input  start, nk_sel, data_in, key_in,
      output nk_val, busy, done, data_out
   );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one CS-low frame sends 128 data + 256 key bits, idles
// TURN_CYC SCK periods while the slave computes, then reads back 128 result bits.
module spi_master #(
   parameter int CLK_DIV  = 2,
   parameter int TURN_CYC = 4
) (
   input  logic       clk,
   input  logic       rst,
   spi_master_if.slave bus,
   output logic       SCK,
   output logic       CS,
   output logic       MOSI,
   input  logic       MISO
);

   localparam int DIV_W = $clog2(CLK_DIV);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEAD  = 3'd1;
   localparam logic [2:0] ST_TX    = 3'd2;
   localparam logic [2:0] ST_TURN  = 3'd3;
   localparam logic [2:0] ST_RX    = 3'd4;
   localparam logic [2:0] ST_TRAIL = 3'd5;

   logic [2:0]       state_reg;
   logic [DIV_W-1:0] div_reg;
   logic [8:0]       bitcnt_reg;
   logic [383:0]     tx_reg;
   logic [127:0]     rx_reg;
   logic [127:0]     data_out_reg;
   logic [1:0]       nk_val_reg;
   logic             sck_reg;
   logic             cs_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             tick;

   assign tick = (state_reg != ST_IDLE) && (div_reg == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         div_reg      <= '0;
         bitcnt_reg   <= '0;
         tx_reg       <= '0;
         rx_reg       <= '0;
         data_out_reg <= '0;
         nk_val_reg   <= '0;
         sck_reg      <= 1'b0;
         cs_reg       <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;

         if (state_reg == ST_IDLE || tick)
            div_reg <= '0;
         else
            div_reg <= div_reg + DIV_W'(1);

         case (state_reg)
            ST_IDLE: begin
               // A start coinciding with the done pulse is dropped, not queued.
               if (bus.start && !done_reg) begin
                  tx_reg     <= {bus.data_in, bus.key_in};
                  nk_val_reg <= bus.nk_sel;
                  busy_reg   <= 1'b1;
                  cs_reg     <= 1'b0;
                  bitcnt_reg <= '0;
                  state_reg  <= ST_LEAD;
               end
            end

            ST_LEAD: begin
               if (tick) begin
                  bitcnt_reg <= '0;
                  state_reg  <= ST_TX;
               end
            end

            ST_TX: begin
               if (tick) begin
                  if (!sck_reg) begin
                     sck_reg <= 1'b1;
                  end else begin
                     // Zero fill means MOSI is already low once the last bit has gone.
                     sck_reg <= 1'b0;
                     tx_reg  <= {tx_reg[382:0], 1'b0};
                     if (bitcnt_reg == 9'd383) begin
                        bitcnt_reg <= '0;
                        state_reg  <= (TURN_CYC == 0) ? ST_RX : ST_TURN;
                     end else begin
                        bitcnt_reg <= bitcnt_reg + 9'd1;
                     end
                  end
               end
            end

            ST_TURN: begin
               if (tick) begin
                  sck_reg <= ~sck_reg;
                  if (sck_reg) begin
                     if (bitcnt_reg == 9'(TURN_CYC - 1)) begin
                        bitcnt_reg <= '0;
                        state_reg  <= ST_RX;
                     end else begin
                        bitcnt_reg <= bitcnt_reg + 9'd1;
                     end
                  end
               end
            end

            ST_RX: begin
               if (tick) begin
                  if (!sck_reg) begin
                     sck_reg <= 1'b1;
                     rx_reg  <= {rx_reg[126:0], MISO};
                  end else begin
                     sck_reg <= 1'b0;
                     if (bitcnt_reg == 9'd127) begin
                        bitcnt_reg <= '0;
                        cs_reg     <= 1'b1;
                        state_reg  <= ST_TRAIL;
                     end else begin
                        bitcnt_reg <= bitcnt_reg + 9'd1;
                     end
                  end
               end
            end

            ST_TRAIL: begin
               if (tick) begin
                  data_out_reg <= rx_reg;
                  done_reg     <= 1'b1;
                  busy_reg     <= 1'b0;
                  state_reg    <= ST_IDLE;
               end
            end

            default: begin
               sck_reg   <= 1'b0;
               cs_reg    <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign SCK          = sck_reg;
   assign CS           = cs_reg;
   assign MOSI         = tx_reg[383];
   assign bus.nk_val   = nk_val_reg;
   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;
   assign bus.data_out = data_out_reg;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: frame vectors against a behavioural AES-slave
// stand-in, plus reset, abort, start-collision and non-default-timing sequences.
module tb_spi_master;

   localparam int LAT1  = (2 + 2 * (512 + 4)) * 2;   // 2068
   localparam int LAT2  = (2 + 2 * (512 + 1)) * 3;   // 3084
   localparam int RXB1  = 384 + 4;                   // rises before the first result bit
   localparam int RXB2  = 384 + 1;

   typedef struct {
      logic [127:0] data;
      logic [255:0] key;
      logic [1:0]   nk;
      logic [127:0] resp;
      bit           poke;
   } vec_t;

   vec_t vec[4];

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   spi_master_if bus1();
   spi_master_if bus2();

   logic sck1, cs1, mosi1;
   logic sck2, cs2, mosi2;
   logic miso1 = 1'b0;
   logic miso2 = 1'b0;

   spi_master #(.CLK_DIV(2), .TURN_CYC(4)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .SCK(sck1), .CS(cs1), .MOSI(mosi1), .MISO(miso1)
   );

   spi_master #(.CLK_DIV(3), .TURN_CYC(1)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2),
      .SCK(sck2), .CS(cs2), .MOSI(mosi2), .MISO(miso2)
   );

   // Slave stand-ins: capture MOSI on SCK rise, shift the response out on SCK fall.
   logic [127:0] resp1 = '0;
   logic [127:0] resp2 = '0;
   logic [383:0] cap1  = '0;
   logic [383:0] cap2  = '0;
   int rise1 = 0;
   int rise2 = 0;

   always @(negedge cs1 or posedge sck1) begin
      if (sck1) begin
         if (rise1 < 384) cap1 = {cap1[382:0], mosi1};
         rise1++;
      end else begin
         rise1 = 0;
      end
   end

   always @(negedge sck1) begin
      if (rise1 >= RXB1 && rise1 < RXB1 + 128) miso1 = resp1[127 - (rise1 - RXB1)];
      else if (rise1 >= 384 && rise1 < RXB1)   miso1 = 1'b1;
      else                                     miso1 = 1'b0;
   end

   always @(negedge cs2 or posedge sck2) begin
      if (sck2) begin
         if (rise2 < 384) cap2 = {cap2[382:0], mosi2};
         rise2++;
      end else begin
         rise2 = 0;
      end
   end

   always @(negedge sck2) begin
      if (rise2 >= RXB2 && rise2 < RXB2 + 128) miso2 = resp2[127 - (rise2 - RXB2)];
      else                                     miso2 = 1'b0;
   end

   task automatic chk(input string name, input logic [383:0] got, input logic [383:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic run_frame(input int vi);
      int c0, rel, lat, bad_cs, busy_falls;
      logic prev_busy;
      bit nk_bad;
      lat = -1; bad_cs = 0; busy_falls = 0; nk_bad = 1'b0; rel = 0;
      @(negedge clk);
      bus1.data_in = vec[vi].data;
      bus1.key_in  = vec[vi].key;
      bus1.nk_sel  = vec[vi].nk;
      resp1        = vec[vi].resp;
      bus1.start   = 1'b1;
      @(posedge clk); #1;
      c0 = cyc;
      bus1.start   = 1'b0;
      bus1.data_in = ~vec[vi].data;
      bus1.key_in  = ~vec[vi].key;
      bus1.nk_sel  = ~vec[vi].nk;
      chk("busy_at_accept", {383'b0, bus1.busy}, 384'd1);
      chk("cs_at_accept", {383'b0, cs1}, 384'd0);
      prev_busy = bus1.busy;
      for (int i = 0; i < LAT1 + 200 && lat < 0; i++) begin
         @(posedge clk); #1;
         rel = cyc - c0;
         if (bus1.nk_val !== vec[vi].nk) nk_bad = 1'b1;
         if (cs1 && rel < LAT1 - 2) bad_cs++;
         if (prev_busy && !bus1.busy) busy_falls++;
         prev_busy = bus1.busy;
         if (bus1.done) lat = rel;
         // Optional collisions: mid-TX (bit 100) and around the done edge.
         bus1.start = vec[vi].poke && (rel == 404 || rel == LAT1 - 1 || rel == LAT1);
      end
      @(posedge clk); #1;
      bus1.start = 1'b0;
      chk("done_one_cycle", {383'b0, bus1.done}, 384'd0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (prev_busy && !bus1.busy) busy_falls++;
         prev_busy = bus1.busy;
         if (bus1.busy || !cs1) bad_cs++;
      end
      chk("latency", 384'(lat), 384'(LAT1));
      chk("mosi_stream", cap1, {vec[vi].data, vec[vi].key});
      chk("data_out", {256'b0, bus1.data_out}, {256'b0, vec[vi].resp});
      chk("nk_val_stable", {383'b0, nk_bad}, 384'd0);
      chk("busy_falls", 384'(busy_falls), 384'd1);
      chk("cs_window", 384'(bad_cs), 384'd0);
      chk("sck_rises", 384'(rise1), 384'(RXB1 + 128));
      $display("frame vec=%0d nk=%b poke=%0d latency=%0d data_out=%h",
               vi, vec[vi].nk, vec[vi].poke, lat, bus1.data_out);
   endtask

   initial begin
      int c0, rel, lat, last, bad_runs, flag;
      logic prev_sck;

      bus1.start = 1'b0; bus1.nk_sel = '0; bus1.data_in = '0; bus1.key_in = '0;
      bus2.start = 1'b0; bus2.nk_sel = '0; bus2.data_in = '0; bus2.key_in = '0;

      vec[0] = '{128'h00112233445566778899aabbccddeeff,
                 {128'h0, 128'h000102030405060708090a0b0c0d0e0f},
                 2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0};
      vec[1] = '{128'h00112233445566778899aabbccddeeff,
                 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                 2'b10, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b0};
      vec[2] = '{128'hf0e1d2c3b4a5968778695a4b3c2d1e0f,
                 {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617},
                 2'b01, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b0};
      vec[3] = '{128'haaaa5555aaaa5555ffff0000ffff0000,
                 {128'h0, 128'h8000000000000000000000000000_0001},
                 2'b00, 128'h0123456789abcdeffedcba9876543210, 1'b1};

      // Reset held with start pulsing: nothing may leave idle.
      rst = 1'b0;
      bus1.start = 1'b1;
      bus2.start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs", {383'b0, cs1}, 384'd1);
      chk("rst_sck", {383'b0, sck1}, 384'd0);
      chk("rst_mosi", {383'b0, mosi1}, 384'd0);
      chk("rst_busy", {383'b0, bus1.busy}, 384'd0);
      chk("rst_done", {383'b0, bus1.done}, 384'd0);
      chk("rst_data_out", {256'b0, bus1.data_out}, 384'd0);
      chk("rst_nk_val", {382'b0, bus1.nk_val}, 384'd0);
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      for (int v = 0; v < 4; v++) run_frame(v);

      // Abort at TX bit 200 with an asynchronous reset.
      @(negedge clk);
      bus1.data_in = vec[1].data;
      bus1.key_in  = vec[1].key;
      bus1.nk_sel  = vec[1].nk;
      resp1        = vec[1].resp;
      bus1.start   = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      for (int i = 0; i < 1000 && rise1 < 201; i++) begin
         @(posedge clk); #1;
      end
      chk("abort_reached_bit200", 384'(rise1), 384'd201);
      #2 rst = 1'b0;
      #1;
      chk("abort_cs", {383'b0, cs1}, 384'd1);
      chk("abort_sck", {383'b0, sck1}, 384'd0);
      chk("abort_mosi", {383'b0, mosi1}, 384'd0);
      chk("abort_busy", {383'b0, bus1.busy}, 384'd0);
      chk("abort_data_out", {256'b0, bus1.data_out}, 384'd0);
      flag = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (bus1.done || bus1.busy || !cs1) flag++;
      end
      chk("abort_no_done", 384'(flag), 384'd0);
      $display("abort at tx bit 200 data_out=%h", bus1.data_out);

      run_frame(0);

      // CLK_DIV=3, TURN_CYC=1 instance.
      @(negedge clk);
      bus2.data_in = vec[0].data;
      bus2.key_in  = vec[0].key;
      bus2.nk_sel  = vec[0].nk;
      resp2        = vec[0].resp;
      bus2.start   = 1'b1;
      @(posedge clk); #1;
      c0 = cyc;
      bus2.start = 1'b0;
      prev_sck = sck2; last = -1; bad_runs = 0; lat = -1; rel = 0;
      for (int i = 0; i < LAT2 + 300 && lat < 0; i++) begin
         @(posedge clk); #1;
         rel = cyc - c0;
         if (sck2 !== prev_sck) begin
            if (last >= 0 && rel - last != 3) bad_runs++;
            last = rel;
            prev_sck = sck2;
         end
         if (bus2.done) lat = rel;
      end
      chk("div3_latency", 384'(lat), 384'(LAT2));
      chk("div3_half_periods", 384'(bad_runs), 384'd0);
      chk("div3_sck_rises", 384'(rise2), 384'(RXB2 + 128));
      chk("div3_mosi_stream", cap2, {vec[0].data, vec[0].key});
      chk("div3_data_out", {256'b0, bus2.data_out}, {256'b0, vec[0].resp});
      $display("frame div3 latency=%0d data_out=%h", lat, bus2.data_out);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
